// File: rtl/video_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen_if
// Description : Pixel request / pixel return bundle between the raster
//               timing generator (master) and an external fixed-latency
//               pixel source (slave).
//               master drives : req_valid, req_x, req_y, frame_start,
//                               line_start
//               master reads  : pix_valid, pix_r, pix_g, pix_b
//               HW / VW must match the generator's $clog2(H_TOTAL) and
//               $clog2(V_TOTAL).
// Revision    : 1.0 - initial release
// ============================================================================
interface video_timing_gen_if #(
  parameter int HW          = 10,
  parameter int VW          = 10,
  parameter int COLOR_WIDTH = 8
);
  logic                   req_valid;
  logic [HW-1:0]          req_x;
  logic [VW-1:0]          req_y;
  logic                   frame_start;
  logic                   line_start;
  logic                   pix_valid;
  logic [COLOR_WIDTH-1:0] pix_r;
  logic [COLOR_WIDTH-1:0] pix_g;
  logic [COLOR_WIDTH-1:0] pix_b;

  modport master (
    output req_valid, req_x, req_y, frame_start, line_start,
    input  pix_valid, pix_r, pix_g, pix_b
  );

  modport slave (
    input  req_valid, req_x, req_y, frame_start, line_start,
    output pix_valid, pix_r, pix_g, pix_b
  );
endinterface
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen
// Description : Parametrised raster timing generator. Issues pixel requests
//               (x, y) ahead of the display, re-aligns the returned colour
//               with registered hsync/vsync/draw_area, and reports frame
//               count and sticky pixel underflow. Start/stop only at frame
//               boundaries.
// Ports       : clk, rst_n (async, active low), enable (run request),
//               bus (video_timing_gen_if.master: request out / pixel in),
//               hsync, vsync, draw_area, red, green, blue (registered video),
//               frame_count (16-bit wrapping), underflow (sticky),
//               underflow_clr.
// Options     : VIDEO_TEST_PATTERN_EN adds input pattern_en selecting an
//               internal colour pattern instead of the pix_* return path.
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
  parameter int H_PIXELS      = 640,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK_PORCH  = 48,
  parameter int V_PIXELS      = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK_PORCH  = 33,
  parameter bit HSYNC_POL     = 1'b1,
  parameter bit VSYNC_POL     = 1'b1,
  parameter int COLOR_WIDTH   = 8,
  parameter int PIX_LATENCY   = 2
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  input  wire logic                   enable,
`ifdef VIDEO_TEST_PATTERN_EN
  input  wire logic                   pattern_en,
`endif
  video_timing_gen_if.master          bus,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        draw_area,
  output logic [COLOR_WIDTH-1:0]      red,
  output logic [COLOR_WIDTH-1:0]      green,
  output logic [COLOR_WIDTH-1:0]      blue,
  output logic [15:0]                 frame_count,
  output logic                        underflow,
  input  wire logic                   underflow_clr
);
  localparam int H_TOTAL = H_PIXELS + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
  localparam int V_TOTAL = V_PIXELS + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam int c_hs_start = H_PIXELS + H_FRONT_PORCH;
  localparam int c_hs_end   = c_hs_start + H_SYNC;
  localparam int c_vs_start = V_PIXELS + V_FRONT_PORCH;
  localparam int c_vs_end   = c_vs_start + V_SYNC;
  localparam logic [HW-1:0] c_h_last = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] c_v_last = VW'(V_TOTAL - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [HW-1:0]            h_q, h_d;
  logic [VW-1:0]            v_q, v_d;
  // request stage
  logic                     req_valid_q, req_valid_d;
  logic [HW-1:0]            req_x_q, req_x_d;
  logic [VW-1:0]            req_y_q, req_y_d;
  logic                     frame_start_q, frame_start_d;
  logic                     line_start_q, line_start_d;
  logic                     req_hs_q, req_hs_d;
  logic                     req_vs_q, req_vs_d;
  // alignment pipeline: stage k holds the request made k+1 cycles ago
  logic [PIX_LATENCY-1:0]   pipe_vis_q, pipe_vis_d;
  logic [PIX_LATENCY-1:0]   pipe_hs_q, pipe_hs_d;
  logic [PIX_LATENCY-1:0]   pipe_vs_q, pipe_vs_d;
`ifdef VIDEO_TEST_PATTERN_EN
  logic [HW-1:0]            pipe_x_q [PIX_LATENCY];
  logic [HW-1:0]            pipe_x_d [PIX_LATENCY];
  logic [VW-1:0]            pipe_y_q [PIX_LATENCY];
  logic [VW-1:0]            pipe_y_d [PIX_LATENCY];
`endif
  // output stage
  logic                     hsync_q, hsync_d;
  logic                     vsync_q, vsync_d;
  logic                     draw_area_q, draw_area_d;
  logic [COLOR_WIDTH-1:0]   red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [15:0]              frame_count_q, frame_count_d;
  logic                     underflow_q, underflow_d;

  logic                     running;
  logic                     underflow_set;
  int                       h_int, v_int;

  assign running = (state_q == ST_RUN);
  assign h_int   = int'(h_q);
  assign v_int   = int'(v_q);

  always_comb begin
    // raster counters and run/idle control
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    case (state_q)
      ST_IDLE: begin
        h_d = '0;
        v_d = '0;
        if (enable) state_d = ST_RUN;
      end
      default: begin
        if (h_q == c_h_last) begin
          h_d = '0;
          if (v_q == c_v_last) begin
            v_d = '0;
            // enable is only honoured at the frame wrap
            if (!enable) state_d = ST_IDLE;
          end else begin
            v_d = v_q + 1'b1;
          end
        end else begin
          h_d = h_q + 1'b1;
        end
      end
    endcase

    // request stage, registered from the current counter position
    req_valid_d   = running && (h_int < H_PIXELS) && (v_int < V_PIXELS);
    req_x_d       = req_valid_d ? h_q : '0;
    req_y_d       = req_valid_d ? v_q : '0;
    frame_start_d = running && (h_q == '0) && (v_q == '0);
    line_start_d  = running && (h_q == '0) && (v_int < V_PIXELS);
    req_hs_d      = running && (h_int >= c_hs_start) && (h_int < c_hs_end);
    req_vs_d      = running && (v_int >= c_vs_start) && (v_int < c_vs_end);

    // alignment pipeline
    pipe_vis_d[0] = req_valid_q;
    pipe_hs_d[0]  = req_hs_q;
    pipe_vs_d[0]  = req_vs_q;
    for (int k = 1; k < PIX_LATENCY; k++) begin
      pipe_vis_d[k] = pipe_vis_q[k-1];
      pipe_hs_d[k]  = pipe_hs_q[k-1];
      pipe_vs_d[k]  = pipe_vs_q[k-1];
    end
`ifdef VIDEO_TEST_PATTERN_EN
    pipe_x_d[0] = req_x_q;
    pipe_y_d[0] = req_y_q;
    for (int k = 1; k < PIX_LATENCY; k++) begin
      pipe_x_d[k] = pipe_x_q[k-1];
      pipe_y_d[k] = pipe_y_q[k-1];
    end
`endif

    // output stage: pix_* belong to the request at the end of the pipeline
    draw_area_d   = pipe_vis_q[PIX_LATENCY-1];
    hsync_d       = pipe_hs_q[PIX_LATENCY-1] ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = pipe_vs_q[PIX_LATENCY-1] ? VSYNC_POL : ~VSYNC_POL;
    red_d         = '0;
    green_d       = '0;
    blue_d        = '0;
    underflow_set = 1'b0;
    if (pipe_vis_q[PIX_LATENCY-1]) begin
`ifdef VIDEO_TEST_PATTERN_EN
      if (pattern_en) begin
        red_d   = COLOR_WIDTH'(pipe_x_q[PIX_LATENCY-1] >> 3);
        green_d = COLOR_WIDTH'(pipe_x_q[PIX_LATENCY-1] >> 2);
        blue_d  = COLOR_WIDTH'(32'(pipe_x_q[PIX_LATENCY-1]) |
                               32'(pipe_y_q[PIX_LATENCY-1]));
      end else
`endif
      if (bus.pix_valid) begin
        red_d   = bus.pix_r;
        green_d = bus.pix_g;
        blue_d  = bus.pix_b;
      end else begin
        underflow_set = 1'b1;
      end
    end

    // a new miss wins over a simultaneous clear
    if (underflow_set)      underflow_d = 1'b1;
    else if (underflow_clr) underflow_d = 1'b0;
    else                    underflow_d = underflow_q;

    frame_count_d = frame_count_q + 16'(frame_start_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      h_q           <= '0;
      v_q           <= '0;
      req_valid_q   <= 1'b0;
      req_x_q       <= '0;
      req_y_q       <= '0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
      req_hs_q      <= 1'b0;
      req_vs_q      <= 1'b0;
      pipe_vis_q    <= '0;
      pipe_hs_q     <= '0;
      pipe_vs_q     <= '0;
`ifdef VIDEO_TEST_PATTERN_EN
      for (int k = 0; k < PIX_LATENCY; k++) begin
        pipe_x_q[k] <= '0;
        pipe_y_q[k] <= '0;
      end
`endif
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      draw_area_q   <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      frame_count_q <= '0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      v_q           <= v_d;
      req_valid_q   <= req_valid_d;
      req_x_q       <= req_x_d;
      req_y_q       <= req_y_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
      req_hs_q      <= req_hs_d;
      req_vs_q      <= req_vs_d;
      pipe_vis_q    <= pipe_vis_d;
      pipe_hs_q     <= pipe_hs_d;
      pipe_vs_q     <= pipe_vs_d;
`ifdef VIDEO_TEST_PATTERN_EN
      for (int k = 0; k < PIX_LATENCY; k++) begin
        pipe_x_q[k] <= pipe_x_d[k];
        pipe_y_q[k] <= pipe_y_d[k];
      end
`endif
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      draw_area_q   <= draw_area_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      frame_count_q <= frame_count_d;
      underflow_q   <= underflow_d;
    end
  end

  assign bus.req_valid   = req_valid_q;
  assign bus.req_x       = req_x_q;
  assign bus.req_y       = req_y_q;
  assign bus.frame_start = frame_start_q;
  assign bus.line_start  = line_start_q;
  assign hsync           = hsync_q;
  assign vsync           = vsync_q;
  assign draw_area       = draw_area_q;
  assign red             = red_q;
  assign green           = green_q;
  assign blue            = blue_q;
  assign frame_count     = frame_count_q;
  assign underflow       = underflow_q;
endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_timing_gen
// Description : Self-checking bench for video_timing_gen on an 8x6 raster
//               (H 4/1/2/1, V 3/1/1/1, PIX_LATENCY 2). A loopback pixel
//               source returns x/y two cycles after each request. A second
//               instance with HSYNC_POL=0 runs in parallel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;
  localparam int HW = 3;
  localparam int VW = 3;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic underflow_clr = 1'b0;
  logic drop_on = 1'b0;

  logic hsync, vsync, draw_area, underflow;
  logic [CW-1:0] red, green, blue;
  logic [15:0] frame_count;
  logic hsync_p0, vsync_p0, draw_area_p0, underflow_p0;
  logic [CW-1:0] red_p0, green_p0, blue_p0;
  logic [15:0] frame_count_p0;

  video_timing_gen_if #(.HW(HW), .VW(VW), .COLOR_WIDTH(CW)) bus ();
  video_timing_gen_if #(.HW(HW), .VW(VW), .COLOR_WIDTH(CW)) bus_p0 ();

  video_timing_gen #(
    .H_PIXELS(4), .H_FRONT_PORCH(1), .H_SYNC(2), .H_BACK_PORCH(1),
    .V_PIXELS(3), .V_FRONT_PORCH(1), .V_SYNC(1), .V_BACK_PORCH(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COLOR_WIDTH(CW), .PIX_LATENCY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
`ifdef VIDEO_TEST_PATTERN_EN
    .pattern_en(1'b0),
`endif
    .bus(bus.master), .hsync(hsync), .vsync(vsync), .draw_area(draw_area),
    .red(red), .green(green), .blue(blue), .frame_count(frame_count),
    .underflow(underflow), .underflow_clr(underflow_clr)
  );

  video_timing_gen #(
    .H_PIXELS(4), .H_FRONT_PORCH(1), .H_SYNC(2), .H_BACK_PORCH(1),
    .V_PIXELS(3), .V_FRONT_PORCH(1), .V_SYNC(1), .V_BACK_PORCH(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .COLOR_WIDTH(CW), .PIX_LATENCY(2)
  ) dut_p0 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
`ifdef VIDEO_TEST_PATTERN_EN
    .pattern_en(1'b0),
`endif
    .bus(bus_p0.master), .hsync(hsync_p0), .vsync(vsync_p0),
    .draw_area(draw_area_p0), .red(red_p0), .green(green_p0), .blue(blue_p0),
    .frame_count(frame_count_p0), .underflow(underflow_p0),
    .underflow_clr(underflow_clr)
  );

  always #5 clk = ~clk;

  // loopback pixel source with two cycles of latency
  logic [HW-1:0] d1_x = '0, d2_x = '0;
  logic [VW-1:0] d1_y = '0, d2_y = '0;
  logic          d1_v = 1'b0, d2_v = 1'b0;
  always @(posedge clk) begin
    d1_x <= bus.req_x;  d2_x <= d1_x;
    d1_y <= bus.req_y;  d2_y <= d1_y;
    d1_v <= bus.req_valid; d2_v <= d1_v;
  end
  logic w_drop;
  assign w_drop = drop_on && d2_v && (d2_y == 3'd1) && ((d2_x == 3'd2) || (d2_x == 3'd3));
  assign bus.pix_valid    = !w_drop;
  assign bus.pix_r        = CW'(d2_x);
  assign bus.pix_g        = CW'(d2_y);
  assign bus.pix_b        = CW'({d2_y, d2_x});
  assign bus_p0.pix_valid = !w_drop;
  assign bus_p0.pix_r     = CW'(d2_x);
  assign bus_p0.pix_g     = CW'(d2_y);
  assign bus_p0.pix_b     = CW'({d2_y, d2_x});

  int n_chk = 0;
  int n_fail = 0;
  int kc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    kc++;
  endtask

  typedef struct {
    int k;
    int rv, x, y, fs, ls;
    int hs, vs, da, r, g, b;
    int fc;
  } vec_t;
  localparam int NV = 21;
  vec_t tbl [NV];

  initial begin
    int cnt;
    int fs_cnt;
    //           k   rv x  y  fs ls  hs vs da r  g  b   fc
    tbl[0]  = '{ 1,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0};
    tbl[1]  = '{ 2,  1, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0,  1};
    tbl[2]  = '{ 3,  1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1};
    tbl[3]  = '{ 5,  1, 3, 0, 0, 0,  0, 0, 1, 0, 0, 0,  1};
    tbl[4]  = '{ 6,  0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 1,  1};
    tbl[5]  = '{ 8,  0, 0, 0, 0, 0,  0, 0, 1, 3, 0, 3,  1};
    tbl[6]  = '{ 9,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1};
    tbl[7]  = '{10,  1, 0, 1, 0, 1,  1, 0, 0, 0, 0, 0,  1};
    tbl[8]  = '{11,  1, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0,  1};
    tbl[9]  = '{12,  1, 2, 1, 0, 0,  0, 0, 0, 0, 0, 0,  1};
    tbl[10] = '{13,  1, 3, 1, 0, 0,  0, 0, 1, 0, 1, 8,  1};
    tbl[11] = '{15,  0, 0, 0, 0, 0,  0, 0, 1, 2, 1, 10, 1};
    tbl[12] = '{18,  1, 0, 2, 0, 1,  1, 0, 0, 0, 0, 0,  1};
    tbl[13] = '{21,  1, 3, 2, 0, 0,  0, 0, 1, 0, 2, 16, 1};
    tbl[14] = '{36,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1};
    tbl[15] = '{37,  0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0,  1};
    tbl[16] = '{42,  0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0,  1};
    tbl[17] = '{44,  0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0,  1};
    tbl[18] = '{45,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1};
    tbl[19] = '{49,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1};
    tbl[20] = '{50,  1, 0, 0, 1, 1,  1, 0, 0, 0, 0, 0,  2};

    // reset state while rst_n is held low
    repeat (3) @(posedge clk);
    #1;
    chk("rst req_valid", int'(bus.req_valid), 0);
    chk("rst hsync", int'(hsync), 0);
    chk("rst vsync", int'(vsync), 0);
    chk("rst hsync pol0", int'(hsync_p0), 1);
    chk("rst frame_count", int'(frame_count), 0);
    rst_n = 1'b1;

    // idle with enable low
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.req_valid || draw_area || hsync || vsync || !hsync_p0 || (red != '0)) cnt++;
    end
    chk("idle activity cycles", cnt, 0);
    chk("idle frame_count", int'(frame_count), 0);
    chk("idle hsync pol0", int'(hsync_p0), 1);

    // first frame, table driven
    enable = 1'b1;
    kc = 0;
    for (int i = 0; i < NV; i++) begin
      while (kc < tbl[i].k) step();
      chk($sformatf("k%0d req_valid", kc), int'(bus.req_valid), tbl[i].rv);
      chk($sformatf("k%0d req_x", kc), int'(bus.req_x), tbl[i].x);
      chk($sformatf("k%0d req_y", kc), int'(bus.req_y), tbl[i].y);
      chk($sformatf("k%0d frame_start", kc), int'(bus.frame_start), tbl[i].fs);
      chk($sformatf("k%0d line_start", kc), int'(bus.line_start), tbl[i].ls);
      chk($sformatf("k%0d hsync", kc), int'(hsync), tbl[i].hs);
      chk($sformatf("k%0d hsync pol0", kc), int'(hsync_p0), 1 - tbl[i].hs);
      chk($sformatf("k%0d vsync", kc), int'(vsync), tbl[i].vs);
      chk($sformatf("k%0d draw_area", kc), int'(draw_area), tbl[i].da);
      chk($sformatf("k%0d red", kc), int'(red), tbl[i].r);
      chk($sformatf("k%0d green", kc), int'(green), tbl[i].g);
      chk($sformatf("k%0d blue", kc), int'(blue), tbl[i].b);
      chk($sformatf("k%0d frame_count", kc), int'(frame_count), tbl[i].fc);
      chk($sformatf("k%0d underflow", kc), int'(underflow), 0);
    end

    // hsync duty over one line; arm the pixel drops for line 1 of frame 1
    drop_on = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (hsync) cnt++;
    end
    chk("hsync high per line", cnt, 2);

    // dropped pixel (2,1) of frame 1 appears at k=63
    while (kc < 62) step();
    chk("k62 red before drop", int'(red), 1);
    chk("k62 underflow before drop", int'(underflow), 0);
    step();
    chk("k63 dropped red", int'(red), 0);
    chk("k63 dropped draw_area", int'(draw_area), 1);
    chk("k63 underflow set", int'(underflow), 1);
    underflow_clr = 1'b1;
    step();
    chk("k64 dropped red", int'(red), 0);
    chk("k64 underflow set over clr", int'(underflow), 1);
    step();
    chk("k65 underflow cleared", int'(underflow), 0);
    underflow_clr = 1'b0;
    drop_on = 1'b0;
    step();
    chk("k66 underflow stays clear", int'(underflow), 0);

    // frame_start period
    fs_cnt = 0;
    while (kc < 98) begin
      step();
      if (bus.frame_start) fs_cnt++;
    end
    chk("k98 frame_start", int'(bus.frame_start), 1);
    chk("frame_start count 67..98", fs_cnt, 1);
    chk("k98 frame_count", int'(frame_count), 3);

    // stop request mid-frame: frame 2 completes, then idle
    while (kc < 110) step();
    enable = 1'b0;
    cnt = 0;
    fs_cnt = 0;
    while (kc < 200) begin
      step();
      if (bus.req_valid) cnt++;
      if (bus.frame_start) fs_cnt++;
      if (kc == 117) begin
        chk("k117 last req_valid", int'(bus.req_valid), 1);
        chk("k117 last req_x", int'(bus.req_x), 3);
        chk("k117 last req_y", int'(bus.req_y), 2);
      end
      if (kc == 146) chk("k146 no restart", int'(bus.req_valid), 0);
    end
    chk("requests after stop", cnt, 4);
    chk("frame_start after stop", fs_cnt, 0);
    chk("stopped frame_count", int'(frame_count), 3);
    chk("stopped hsync", int'(hsync), 0);
    chk("stopped hsync pol0", int'(hsync_p0), 1);
    chk("stopped draw_area", int'(draw_area), 0);

    // restart then asynchronous reset mid-frame
    enable = 1'b1;
    while (kc < 205) step();
    chk("k205 restart req_valid", int'(bus.req_valid), 1);
    chk("k205 restart frame_count", int'(frame_count), 4);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst req_valid", int'(bus.req_valid), 0);
    chk("async rst frame_count", int'(frame_count), 0);
    chk("async rst draw_area", int'(draw_area), 0);
    chk("async rst hsync pol0", int'(hsync_p0), 1);
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
